ad9866_cmd_arb: RTL and testbench

AD9866_CMD_ARB -- requirements
Module: ad9866_cmd_arb

---
 rtl/ad9866_arb_pkg.sv | 19 +
 rtl/ad9866_cmd_arb_rr_pick.sv | 35 +++
 rtl/ad9866_cmd_arb.sv | 119 +++++++++++
 tb/tb_ad9866_cmd_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9866_arb_pkg.sv
// Shared types and defaults for the AD9866 control-command arbiter.
package ad9866_arb_pkg;

  localparam int DEF_NREQ    = 3;
  localparam int DEF_TIMEOUT = 255;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ad9866_cmd_arb_rr_pick.sv
// Round-robin pick: first requester at or after last_grant+1, wrapping to 0.
module rr_pick
  import ad9866_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]                req,
  input  logic [idx_width(NREQ)-1:0]     last_grant,
  output logic                           valid,
  output logic [idx_width(NREQ)-1:0]     idx
);

  localparam int IDX_W = idx_width(NREQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output and temporary gets a default before the loop so no
  // path through this block leaves a value held, which would infer a latch.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(last_grant) + i) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ad9866_cmd_arb.sv
// Arbitrates NREQ command requesters onto the single AD9866 control slave,
// with registered command outputs, an ack timeout and a one-cycle gap.
module ad9866_cmd_arb
  import ad9866_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6*NREQ-1:0]    rq_addr,
  input  logic [32*NREQ-1:0]   rq_data,
  input  logic [NREQ-1:0]      rq_rqst,
  output logic [NREQ-1:0]      rq_ack,
  output logic [NREQ-1:0]      rq_nak,
  output logic [5:0]           cmd_addr,
  output logic [31:0]          cmd_data,
  output logic                 cmd_rqst,
  input  logic                 cmd_ack,
  output logic                 busy
);

  localparam int               IDX_W       = idx_width(NREQ);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [5:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             cmd_rqst_q, cmd_rqst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  nak_q, nak_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (rq_rqst),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    nak_d        = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_ISSUE;
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          addr_d       = rq_addr[int'(pick_idx)*6 +: 6];
          data_d       = rq_data[int'(pick_idx)*32 +: 32];
          cnt_d        = '0;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the timeout cycle still wins over the nak.
        if (cmd_ack) begin
          ack_d[grant_q] = 1'b1;
          state_d        = ST_GAP;
        end else if (cnt_q == TIMEOUT_CNT) begin
          nak_d[grant_q] = 1'b1;
          state_d        = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_rqst_d = (state_d == ST_ISSUE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop; reset covers all control and
  // output registers so nothing leaves reset undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NREQ - 1);
      addr_q       <= '0;
      data_q       <= '0;
      cmd_rqst_q   <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= '0;
      nak_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cmd_rqst_q   <= cmd_rqst_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      nak_q        <= nak_d;
    end
  end

  assign cmd_rqst = cmd_rqst_q;
  assign cmd_addr = addr_q;
  assign cmd_data = data_q;
  assign rq_ack   = ack_q;
  assign rq_nak   = nak_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ad9866_cmd_arb.sv
// Directed self-checking bench for ad9866_cmd_arb with default parameters.
module tb_ad9866_cmd_arb;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 255;

  logic                clk = 1'b0;
  logic                rst;
  logic [6*NREQ-1:0]   rq_addr;
  logic [32*NREQ-1:0]  rq_data;
  logic [NREQ-1:0]     rq_rqst;
  logic [NREQ-1:0]     rq_ack;
  logic [NREQ-1:0]     rq_nak;
  logic [5:0]          cmd_addr;
  logic [31:0]         cmd_data;
  logic                cmd_rqst;
  logic                cmd_ack;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  ad9866_cmd_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rq_addr  (rq_addr),
    .rq_data  (rq_data),
    .rq_rqst  (rq_rqst),
    .rq_ack   (rq_ack),
    .rq_nak   (rq_nak),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_rqst (cmd_rqst),
    .cmd_ack  (cmd_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic apply_reset();
    rst     = 1'b1;
    rq_rqst = '0;
    cmd_ack = 1'b0;
    rq_addr = '0;
    rq_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cmd(input int max_cycles, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < max_cycles && !ok) begin
      if (cmd_rqst === 1'b1) ok = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    rq_rqst = 3'b100;
    cmd_ack = 1'b0;
    rq_addr = '1;
    rq_data = '1;
    #1;
    checks++;
    if ({cmd_rqst, busy, rq_ack, rq_nak} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected %b", {cmd_rqst, busy, rq_ack, rq_nak}, 8'h00);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cmd_addr !== 6'h00 || cmd_data !== 32'h0 || cmd_rqst !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: got addr=%h data=%h rqst=%b busy=%b expected all zero",
               cmd_addr, cmd_data, cmd_rqst, busy);
    end
    rst     = 1'b0;
    rq_rqst = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    rq_addr[5:0]  = 6'h09;
    rq_data[31:0] = 32'h8000_0000;
    rq_rqst       = 3'b001;
    @(negedge clk);
    checks++;
    if (cmd_rqst !== 1'b1 || cmd_addr !== 6'h09 || cmd_data !== 32'h8000_0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue: got rqst=%b addr=%h data=%h busy=%b expected 1 09 80000000 1",
               cmd_rqst, cmd_addr, cmd_data, busy);
    end
    @(negedge clk);
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ack !== 3'b001 || rq_nak !== 3'b000 || cmd_rqst !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_ack: got ack=%b nak=%b rqst=%b busy=%b expected 001 000 0 1",
               rq_ack, rq_nak, cmd_rqst, busy);
    end
    cmd_ack = 1'b0;
    rq_rqst = 3'b000;
    @(negedge clk);
    checks++;
    if (rq_ack !== 3'b000 || busy !== 1'b0 || cmd_rqst !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got ack=%b busy=%b rqst=%b expected 000 0 0", rq_ack, busy, cmd_rqst);
    end
  endtask

  task automatic test_round_robin();
    int          order [4] = '{0, 1, 2, 0};
    bit          ok;
    logic [5:0]  exp_addr;
    logic [2:0]  exp_ack;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      rq_addr[6*i +: 6]   = 6'h11 + 6'(i);
      rq_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
    rq_rqst = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_addr = 6'h11 + 6'(order[k]);
      exp_ack  = 3'b001 << order[k];
      wait_cmd(4, ok);
      checks++;
      if (!ok || cmd_addr !== exp_addr) begin
        failures++;
        $display("FAIL rr_grant%0d: got rqst=%b addr=%h expected 1 %h", k, cmd_rqst, cmd_addr, exp_addr);
      end
      cmd_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (rq_ack !== exp_ack || rq_nak !== 3'b000) begin
        failures++;
        $display("FAIL rr_ack%0d: got ack=%b nak=%b expected %b 000", k, rq_ack, rq_nak, exp_ack);
      end
      cmd_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (rq_ack !== 3'b000 || cmd_rqst !== 1'b0) begin
        failures++;
        $display("FAIL rr_pulse%0d: got ack=%b rqst=%b expected 000 0", k, rq_ack, cmd_rqst);
      end
    end
    rq_rqst = 3'b000;
    @(negedge clk);
    if (cmd_rqst === 1'b1) begin
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    apply_reset();
    rq_addr[5:0]  = 6'h21;
    rq_addr[11:6] = 6'h22;
    rq_rqst       = 3'b011;
    wait_cmd(4, ok);
    checks++;
    if (!ok || cmd_addr !== 6'h21) begin
      failures++;
      $display("FAIL to_grant: got rqst=%b addr=%h expected 1 21", cmd_rqst, cmd_addr);
    end
    n = 0;
    while (cmd_rqst === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL to_length: got %0d issue cycles expected 256", n);
    end
    checks++;
    if (rq_nak !== 3'b001 || rq_ack !== 3'b000 || cmd_rqst !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL to_nak: got nak=%b ack=%b rqst=%b busy=%b expected 001 000 0 1",
               rq_nak, rq_ack, cmd_rqst, busy);
    end
    @(negedge clk);
    checks++;
    if (rq_nak !== 3'b000 || cmd_rqst !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_gap: got nak=%b rqst=%b busy=%b expected 000 0 0", rq_nak, cmd_rqst, busy);
    end
    @(negedge clk);
    checks++;
    if (cmd_rqst !== 1'b1 || cmd_addr !== 6'h22) begin
      failures++;
      $display("FAIL to_next: got rqst=%b addr=%h expected 1 22", cmd_rqst, cmd_addr);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    rq_rqst = 3'b000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_drop_mid_issue();
    apply_reset();
    rq_addr[5:0]  = 6'h15;
    rq_data[31:0] = 32'hDEAD_BEEF;
    rq_rqst       = 3'b001;
    @(negedge clk);
    rq_rqst       = 3'b000;
    rq_addr[5:0]  = 6'h2A;
    rq_data[31:0] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_rqst !== 1'b1 || cmd_addr !== 6'h15 || cmd_data !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL drop_hold%0d: got rqst=%b addr=%h data=%h expected 1 15 deadbeef",
                 i, cmd_rqst, cmd_addr, cmd_data);
      end
      @(negedge clk);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ack !== 3'b001) begin
      failures++;
      $display("FAIL drop_ack: got %b expected 001", rq_ack);
    end
    cmd_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cmd_rqst !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_noreissue: got rqst=%b busy=%b expected 0 0", cmd_rqst, busy);
    end
  endtask

  task automatic test_reset_in_issue();
    bit ok;
    apply_reset();
    rq_addr[5:0]  = 6'h31;
    rq_addr[11:6] = 6'h32;
    rq_rqst       = 3'b011;
    wait_cmd(4, ok);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    wait_cmd(4, ok);
    checks++;
    if (!ok || cmd_addr !== 6'h32) begin
      failures++;
      $display("FAIL rsti_second: got rqst=%b addr=%h expected 1 32", cmd_rqst, cmd_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cmd_rqst !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rsti_async: got rqst=%b busy=%b expected 0 0", cmd_rqst, busy);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ack !== 3'b000 || rq_nak !== 3'b000 || cmd_rqst !== 1'b0) begin
      failures++;
      $display("FAIL rsti_nopulse: got ack=%b nak=%b rqst=%b expected 000 000 0", rq_ack, rq_nak, cmd_rqst);
    end
    cmd_ack = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_rqst !== 1'b1 || cmd_addr !== 6'h31) begin
      failures++;
      $display("FAIL rsti_prio: got rqst=%b addr=%h expected 1 31", cmd_rqst, cmd_addr);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    rq_rqst = 3'b000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_idle_ack_and_coincident();
    bit ok;
    apply_reset();
    cmd_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rq_ack !== 3'b000 || rq_nak !== 3'b000 || cmd_rqst !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: got busy=%b ack=%b nak=%b rqst=%b expected 0 000 000 0",
               busy, rq_ack, rq_nak, cmd_rqst);
    end
    cmd_ack      = 1'b0;
    rq_addr[5:0] = 6'h3C;
    rq_rqst      = 3'b001;
    wait_cmd(4, ok);
    repeat (255) @(negedge clk);
    checks++;
    if (cmd_rqst !== 1'b1 || rq_nak !== 3'b000) begin
      failures++;
      $display("FAIL coin_pre: got rqst=%b nak=%b expected 1 000", cmd_rqst, rq_nak);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ack !== 3'b001 || rq_nak !== 3'b000) begin
      failures++;
      $display("FAIL coin_ack: got ack=%b nak=%b expected 001 000", rq_ack, rq_nak);
    end
    cmd_ack = 1'b0;
    rq_rqst = 3'b000;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    rq_rqst = '0;
    rq_addr = '0;
    rq_data = '0;
    cmd_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_drop_mid_issue();
    test_reset_in_issue();
    test_idle_ack_and_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
